lfsr_seq_checker: RTL and testbench
===================================

Name: lfsr_seq_checker

Overview:
- Downstream consumer of the 4-bit shift-register sequence generator, which implements next = {q1^q0, q3, q2, q1}, has a maximal period of 15 and seeds at 0111.
- Samples the generator's 4-bit state on each qualified clock, self-synchronises to it, and predicts every following state.
- Declares lock, counts mismatches and measures the sequence period.
- Used as the on-chip / bench monitor proving the generator runs its full 15-state cycle.

Parameters:
- LOCK_COUNT, 4: consecutive correct predictions needed to go from CHECK to LOCKED.
- UNLOCK_MISSES, 3: consecutive mispredictions in LOCKED that force a return to HUNT.
- ERR_W, 8: width of the saturating error counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_state is sampled on this clock edge when high.
- in_state  input  4  generator state {q3,q2,q1,q0}.
- locked  output  1  checker is in LOCKED.
- err_pulse  output  1  one-cycle pulse for each mismatching sample while LOCKED.
- err_count  output  ERR_W  number of LOCKED mismatches, saturating.
- stuck_zero  output  1  sticky flag: an all-zero sample (the lockup state) was seen.
- period  output  5  last measured period, in valid samples.
- period_valid  output  1  one-cycle pulse when period updates.

Behaviour:
- Reset (rst_n low, asynchronous)
  - State = HUNT; pred = 0; match_cnt = 0; miss_cnt = 0; seed = 0; per_cnt = 0.
  - All outputs 0.
- Next-state function
  - nxt(s) = {s[1]^s[0], s[3], s[2], s[1]}.
  - All state updates occur only on edges where in_valid = 1. With in_valid = 0 every register holds.
- Latency
  - All outputs are registered.
  - A response (err_pulse, locked, period_valid) appears in the cycle after the edge that sampled the causing input.
- State HUNT
  - Valid sample == 0000: set stuck_zero; stay in HUNT.
  - Valid nonzero sample: pred <= nxt(in_state); match_cnt <= 0; go to CHECK.
- State CHECK
  - in_state == pred: pred <= nxt(pred); match_cnt++.
    - If match_cnt reaches LOCK_COUNT: go to LOCKED; seed <= in_state; per_cnt <= 1.
  - Mismatch: resynchronise with pred <= nxt(in_state) and match_cnt <= 0; stay in CHECK.
  - No err_pulse is produced in CHECK.
  - A 0000 sample sets stuck_zero and returns to HUNT.
- State LOCKED (locked = 1)
  - pred always advances from the predicted value (pred <= nxt(pred)), never from the received sample. A single corrupted sample therefore costs exactly one error.
  - Match: miss_cnt <= 0.
  - Mismatch: err_pulse = 1; err_count++ (saturates at all-ones); miss_cnt++.
  - When miss_cnt reaches UNLOCK_MISSES: go to HUNT; locked drops; match_cnt and miss_cnt clear.
- Period measurement (LOCKED only)
  - per_cnt increments on each valid sample.
  - Valid sample == seed with per_cnt != 0: period <= per_cnt; period_valid pulses; per_cnt <= 1.
  - per_cnt saturates at 31. A saturated value is reported only if seed recurs.
  - period holds its last value after the checker leaves LOCKED.
- Persistence
  - stuck_zero and err_count clear only on reset.
- Simultaneous events
  - The mismatch that hits UNLOCK_MISSES still produces err_pulse and err_count++ in the same cycle that locked falls.
  - The seed compare uses the received sample. A mismatched sample equal to seed still closes the period.
- Reset mid-operation
  - Immediate return to reset values regardless of state.
  - No pulse is emitted on the way out.

Test Plan:
- Generator from seed 0111, in_valid = 1 every cycle:
  - HUNT→CHECK on the first sample.
  - locked = 1 one cycle after the 5th sample (1 seed sample + 4 matches).
  - period_valid pulses with period = 15 every 15 samples.
  - err_count stays 0.
- While locked, force a single sample 0011→0111:
  - Exactly one err_pulse; err_count = 1; locked stays 1.
  - The next sample matches.
  - The period pulse still reports 15.
- While locked, freeze in_state at 1001 for 4 cycles:
  - err_pulse on 3 samples; err_count = 3.
  - locked = 0 after the 3rd miss; state is HUNT.
  - On release, relock after 5 more samples.
- Drive in_state = 0000 after reset:
  - stuck_zero = 1 and remains 1; locked stays 0.
  - A later valid sequence still locks normally.
- Toggle in_valid 1,0,1,0 with the generator advancing only on valid cycles:
  - Locks after 5 valid samples.
  - period = 15 counts valid samples only, with no errors.
- Assert rst_n low mid-LOCKED, asynchronously between edges:
  - locked, err_count, period and stuck_zero go to 0 immediately.
  - After release, the first sample goes to HUNT→CHECK.

Source files
------------

// File: rtl/lfsr_seq_checker.sv
// Monitor for the 4-bit {q1^q0,q3,q2,q1} shift-register generator: syncs to its
// state stream, predicts every next state, declares lock, counts errors, measures period.
module lfsr_seq_checker #(
    parameter int LOCK_COUNT    = 4,
    parameter int UNLOCK_MISSES = 3,
    parameter int ERR_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [3:0]       in_state,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic             stuck_zero,
    output logic [4:0]       period,
    output logic             period_valid
);

    typedef enum logic [1:0] {HUNT, CHECK, LOCKED} state_e;

    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam int SW = $clog2(UNLOCK_MISSES + 1);
    localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_COUNT - 1);
    localparam logic [SW-1:0] MISS_LAST  = SW'(UNLOCK_MISSES - 1);

    function automatic logic [3:0] nxt(input logic [3:0] s);
        return {s[1] ^ s[0], s[3], s[2], s[1]};
    endfunction

    state_e           state_q, state_d;
    logic [3:0]       pred_q, pred_d;
    logic [3:0]       seed_q, seed_d;
    logic [MW-1:0]    match_cnt_q, match_cnt_d;
    logic [SW-1:0]    miss_cnt_q, miss_cnt_d;
    logic [4:0]       per_cnt_q, per_cnt_d;
    logic [4:0]       period_q, period_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;
    logic             stuck_zero_q, stuck_zero_d;
    logic             locked_q, locked_d;
    logic             err_pulse_q, err_pulse_d;
    logic             period_valid_q, period_valid_d;

    always_comb begin
        // NOTE: every _d gets a default before any branch, so no path can infer a latch.
        state_d        = state_q;
        pred_d         = pred_q;
        seed_d         = seed_q;
        match_cnt_d    = match_cnt_q;
        miss_cnt_d     = miss_cnt_q;
        per_cnt_d      = per_cnt_q;
        period_d       = period_q;
        err_count_d    = err_count_q;
        stuck_zero_d   = stuck_zero_q;
        err_pulse_d    = 1'b0;
        period_valid_d = 1'b0;

        if (in_valid) begin
            if (in_state == 4'b0000) stuck_zero_d = 1'b1;

            unique case (state_q)
                HUNT: begin
                    if (in_state != 4'b0000) begin
                        pred_d      = nxt(in_state);
                        match_cnt_d = '0;
                        state_d     = CHECK;
                    end
                end

                CHECK: begin
                    if (in_state == 4'b0000) begin
                        match_cnt_d = '0;
                        state_d     = HUNT;
                    end else if (in_state == pred_q) begin
                        pred_d = nxt(pred_q);
                        if (match_cnt_q == MATCH_LAST) begin
                            match_cnt_d = '0;
                            miss_cnt_d  = '0;
                            seed_d      = in_state;
                            per_cnt_d   = 5'd1;
                            state_d     = LOCKED;
                        end else begin
                            match_cnt_d = match_cnt_q + MW'(1);
                        end
                    end else begin
                        pred_d      = nxt(in_state);
                        match_cnt_d = '0;
                    end
                end

                LOCKED: begin
                    // Free-run from the prediction so one bad sample costs one error.
                    pred_d = nxt(pred_q);

                    if (in_state == seed_q && per_cnt_q != 5'd0) begin
                        period_d       = per_cnt_q;
                        period_valid_d = 1'b1;
                        per_cnt_d      = 5'd1;
                    end else if (per_cnt_q != 5'd31) begin
                        per_cnt_d = per_cnt_q + 5'd1;
                    end

                    if (in_state == pred_q) begin
                        miss_cnt_d = '0;
                    end else begin
                        err_pulse_d = 1'b1;
                        if (err_count_q != '1) err_count_d = err_count_q + ERR_W'(1);
                        if (miss_cnt_q == MISS_LAST) begin
                            miss_cnt_d  = '0;
                            match_cnt_d = '0;
                            state_d     = HUNT;
                        end else begin
                            miss_cnt_d = miss_cnt_q + SW'(1);
                        end
                    end
                end

                default: state_d = HUNT;
            endcase
        end

        locked_d = (state_d == LOCKED);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= HUNT;
            pred_q         <= '0;
            seed_q         <= '0;
            match_cnt_q    <= '0;
            miss_cnt_q     <= '0;
            per_cnt_q      <= '0;
            period_q       <= '0;
            err_count_q    <= '0;
            stuck_zero_q   <= 1'b0;
            locked_q       <= 1'b0;
            err_pulse_q    <= 1'b0;
            period_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            pred_q         <= pred_d;
            seed_q         <= seed_d;
            match_cnt_q    <= match_cnt_d;
            miss_cnt_q     <= miss_cnt_d;
            per_cnt_q      <= per_cnt_d;
            period_q       <= period_d;
            err_count_q    <= err_count_d;
            stuck_zero_q   <= stuck_zero_d;
            locked_q       <= locked_d;
            err_pulse_q    <= err_pulse_d;
            period_valid_q <= period_valid_d;
        end
    end

    assign locked       = locked_q;
    assign err_pulse    = err_pulse_q;
    assign err_count    = err_count_q;
    assign stuck_zero   = stuck_zero_q;
    assign period       = period_q;
    assign period_valid = period_valid_q;

endmodule

// File: tb/tb_lfsr_seq_checker.sv
// Directed bench for lfsr_seq_checker: lock, single corruption, freeze/unlock,
// stuck-zero, gapped valid and asynchronous mid-lock reset.
module tb_lfsr_seq_checker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] in_state;
    logic       locked;
    logic       err_pulse;
    logic [7:0] err_count;
    logic       stuck_zero;
    logic [4:0] period;
    logic       period_valid;

    int n_checks = 0;
    int n_fail   = 0;
    logic [3:0] g;

    lfsr_seq_checker #(.LOCK_COUNT(4), .UNLOCK_MISSES(3), .ERR_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_state     (in_state),
        .locked       (locked),
        .err_pulse    (err_pulse),
        .err_count    (err_count),
        .stuck_zero   (stuck_zero),
        .period       (period),
        .period_valid (period_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] nxt(input logic [3:0] s);
        return {s[1] ^ s[0], s[3], s[2], s[1]};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Present one sample, let the edge take it, look 1 ns later.
    task automatic sample(input logic v, input logic [3:0] s);
        in_valid = v;
        in_state = s;
        @(posedge clk);
        #1;
    endtask

    task automatic feed();
        sample(1'b1, g);
        g = nxt(g);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_locked"},       32'(locked),       0);
        check({tag, "_err_pulse"},    32'(err_pulse),    0);
        check({tag, "_err_count"},    32'(err_count),    0);
        check({tag, "_stuck_zero"},   32'(stuck_zero),   0);
        check({tag, "_period"},       32'(period),       0);
        check({tag, "_period_valid"}, 32'(period_valid), 0);
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_state = 4'b0000;
        #12;
        check_reset_values("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // All-zero lockup samples: sticky flag, no lock.
        sample(1'b1, 4'b0000);
        check("zero_sticky", 32'(stuck_zero), 1);
        sample(1'b1, 4'b0000);
        check("zero_no_lock", 32'(locked), 0);
        sample(1'b0, 4'b0111);
        check("zero_sticky_hold", 32'(stuck_zero), 1);

        // Clean run from 0111; lock on sample 5 (seed 0100), period pulses on 20, 35.
        g = 4'b0111;
        for (int n = 1; n <= 46; n++) begin
            feed();
            check("clean_no_err", 32'(err_pulse), 0);
            if (n == 4)  check("lock_not_yet", 32'(locked), 0);
            if (n == 5)  check("lock_after_5", 32'(locked), 1);
            if (n == 19) check("no_early_period", 32'(period_valid), 0);
            if (n == 20 || n == 35) begin
                check("period_pulse", 32'(period_valid), 1);
                check("period_15", 32'(period), 15);
            end
            if (n == 21) check("period_pulse_width", 32'(period_valid), 0);
        end
        check("clean_err_count", 32'(err_count), 0);
        check("clean_stuck_kept", 32'(stuck_zero), 1);

        // Sample 47 should be 0011; corrupt it to 0111.
        sample(1'b1, 4'b0111);
        g = nxt(g);
        check("corrupt_err_pulse", 32'(err_pulse), 1);
        check("corrupt_err_count", 32'(err_count), 1);
        check("corrupt_still_locked", 32'(locked), 1);
        feed();
        check("corrupt_next_ok", 32'(err_pulse), 0);
        check("corrupt_next_locked", 32'(locked), 1);
        feed();
        feed();
        check("corrupt_period_pulse", 32'(period_valid), 1);
        check("corrupt_period_15", 32'(period), 15);
        feed();

        // Sample 52 is genuinely 1001; hold it there for 4 samples.
        for (int k = 0; k < 4; k++) begin
            sample(1'b1, 4'b1001);
            check("freeze_err_pulse", 32'(err_pulse), (k != 0) ? 1 : 0);
            check("freeze_locked", 32'(locked), (k < 3) ? 1 : 0);
        end
        check("freeze_err_count", 32'(err_count), 4);
        check("freeze_period_held", 32'(period), 15);
        g = 4'b1100;
        for (int n = 1; n <= 5; n++) begin
            feed();
            check("relock_no_err", 32'(err_pulse), 0);
            if (n == 4) check("relock_not_yet", 32'(locked), 0);
            if (n == 5) check("relock_after_5", 32'(locked), 1);
        end

        // Asynchronous reset between edges while locked.
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_values("async_rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Gapped valid; invalid cycles carry 0000, which must be ignored.
        g = 4'b0111;
        for (int n = 1; n <= 21; n++) begin
            feed();
            check("gap_no_err", 32'(err_pulse), 0);
            if (n == 4)  check("gap_lock_not_yet", 32'(locked), 0);
            if (n == 5)  check("gap_lock_after_5", 32'(locked), 1);
            if (n == 20) begin
                check("gap_period_pulse", 32'(period_valid), 1);
                check("gap_period_15", 32'(period), 15);
            end
            sample(1'b0, 4'b0000);
            if (n == 20) check("gap_pulse_drop", 32'(period_valid), 0);
            if (n == 5)  check("gap_lock_hold", 32'(locked), 1);
        end
        check("gap_err_count", 32'(err_count), 0);
        check("gap_stuck_clear", 32'(stuck_zero), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
